// File: rtl/line_seq_pkg.sv
// Shared types for the line_sequencer command front end: coordinate width,
// buffered command payload, sequencer states and endpoint normalisation.
package line_seq_pkg;

  localparam int unsigned COORD_W = 11;
  localparam int unsigned WDOG_W  = 13;

  typedef struct packed {
    logic [COORD_W-1:0] x0;
    logic [COORD_W-1:0] y0;
    logic [COORD_W-1:0] x1;
    logic [COORD_W-1:0] y1;
    logic               pen;
    logic               clear;
  } line_cmd_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAW  = 2'd2,
    CLEAR = 2'd3
  } seq_state_t;

  // Order endpoints so the drawer always walks left to right.
  function automatic line_cmd_t normalise(input line_cmd_t c);
    line_cmd_t n;
    n = c;
    if (c.x0 > c.x1) begin
      n.x0 = c.x1;
      n.y0 = c.y1;
      n.x1 = c.x0;
      n.y1 = c.y0;
    end
    return n;
  endfunction

endpackage

// File: rtl/seq_fifo.sv
// Synchronous command FIFO of line_cmd_t with full/empty flags.
// Pointers reset asynchronously to empty; storage is not reset.
module seq_fifo
  import line_seq_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push,
  input  logic      pop,
  input  line_cmd_t wr_data,
  output line_cmd_t rd_data,
  output logic      full,
  output logic      empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  line_cmd_t       mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  // A full FIFO refuses a push even when a pop happens in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/line_sequencer.sv
// Command front end for line_drawer: buffers host line commands, loads one line at
// a time into the drawer and forwards its pixels. LINE_SEQ_CLEAR_EN adds a clear sweep.
module line_sequencer
  import line_seq_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned MAX_LINE_CYCLES = 4096,
  parameter int unsigned SCREEN_W        = 640,
  parameter int unsigned SCREEN_H        = 480
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [COORD_W-1:0] cmd_x0,
  input  logic [COORD_W-1:0] cmd_y0,
  input  logic [COORD_W-1:0] cmd_x1,
  input  logic [COORD_W-1:0] cmd_y1,
  input  logic               cmd_pen,
  input  logic               cmd_clear,
  output logic               drw_reset,
  output logic [COORD_W-1:0] drw_x0,
  output logic [COORD_W-1:0] drw_y0,
  output logic [COORD_W-1:0] drw_x1,
  output logic [COORD_W-1:0] drw_y1,
  input  logic [COORD_W-1:0] drw_x,
  input  logic [COORD_W-1:0] drw_y,
  input  logic               drw_done,
  output logic               pix_we,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  output logic               pix_color,
  output logic               busy,
  output logic               err_timeout
);

  line_cmd_t          push_cmd;
  line_cmd_t          head_cmd;
  line_cmd_t          cur;
  seq_state_t         state;
  logic               fifo_full;
  logic               fifo_empty;
  logic               pop;
  logic [WDOG_W-1:0]  wdog;
  logic               unused_ok;

`ifdef LINE_SEQ_CLEAR_EN
  logic [COORD_W-1:0] clr_x;
  logic [COORD_W-1:0] clr_y;
`endif

  assign push_cmd = '{x0: cmd_x0, y0: cmd_y0, x1: cmd_x1, y1: cmd_y1,
                      pen: cmd_pen, clear: cmd_clear};

  assign cmd_ready = !fifo_full;
  assign pop       = (state == IDLE) && !fifo_empty;
  assign busy      = (state != IDLE) || !fifo_empty;

  assign drw_x0 = cur.x0;
  assign drw_y0 = cur.y0;
  assign drw_x1 = cur.x1;
  assign drw_y1 = cur.y1;

  assign unused_ok = cur.clear ^ (SCREEN_W == 0) ^ (SCREEN_H == 0);

  seq_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (cmd_valid),
    .pop     (pop),
    .wr_data (push_cmd),
    .rd_data (head_cmd),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Sequencer: drawer reset is held high everywhere except DRAW.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cur         <= '0;
      wdog        <= '0;
      drw_reset   <= 1'b1;
      err_timeout <= 1'b0;
`ifdef LINE_SEQ_CLEAR_EN
      clr_x       <= '0;
      clr_y       <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            cur   <= normalise(head_cmd);
            state <= LOAD;
`ifdef LINE_SEQ_CLEAR_EN
            if (head_cmd.clear) state <= CLEAR;
`endif
          end
        end
        LOAD: begin
          wdog      <= '0;
          state     <= DRAW;
          drw_reset <= 1'b0;
        end
        DRAW: begin
          wdog <= wdog + WDOG_W'(1);
          if (drw_done) begin
            state     <= IDLE;
            drw_reset <= 1'b1;
          end else if (wdog == WDOG_W'(MAX_LINE_CYCLES - 1)) begin
            state       <= IDLE;
            drw_reset   <= 1'b1;
            err_timeout <= 1'b1;
          end
        end
`ifdef LINE_SEQ_CLEAR_EN
        CLEAR: begin
          if (clr_x == COORD_W'(SCREEN_W - 1)) begin
            clr_x <= '0;
            if (clr_y == COORD_W'(SCREEN_H - 1)) begin
              clr_y <= '0;
              state <= IDLE;
            end else begin
              clr_y <= clr_y + COORD_W'(1);
            end
          end else begin
            clr_x <= clr_x + COORD_W'(1);
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

  // Pixel port: drawer coordinates pass straight through while drawing.
  always_comb begin
    pix_we    = 1'b0;
    pix_x     = '0;
    pix_y     = '0;
    pix_color = 1'b0;
    if (state == DRAW) begin
      pix_we    = !drw_done;
      pix_x     = drw_x;
      pix_y     = drw_y;
      pix_color = cur.pen;
    end
`ifdef LINE_SEQ_CLEAR_EN
    else if (state == CLEAR) begin
      pix_we = 1'b1;
      pix_x  = clr_x;
      pix_y  = clr_y;
    end
`endif
  end

endmodule

// File: doc/line_sequencer.md
# line_sequencer

Command front end for `line_drawer`.
- Accepts line commands from the host over a valid/ready handshake and buffers them in a small FIFO.
- Normalises endpoints, then drives `line_drawer` one line at a time by holding its `reset` high while the endpoints are loaded.
- Forwards the drawer's coordinate stream to the VGA framebuffer as pixel writes.
- A watchdog aborts any line that fails to finish.

## Interface
Parameters:
- FIFO_DEPTH, 4: command FIFO entries (power of two)
- MAX_LINE_CYCLES, 4096: DRAW-state cycle limit before abort
- SCREEN_W, 640: clear-sweep width
- SCREEN_H, 480: clear-sweep height

Ports:
- clk  in  1  system clock, 50 MHz
- reset  in  1  asynchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  FIFO not full
- cmd_x0, cmd_y0, cmd_x1, cmd_y1  in  11 each  endpoints
- cmd_pen  in  1  pixel colour (1 draw, 0 erase)
- cmd_clear  in  1  clear-screen command (see Configuration)
- drw_reset  out  1  to `line_drawer` reset
- drw_x0, drw_y0, drw_x1, drw_y1  out  11 each  to `line_drawer` endpoints
- drw_x, drw_y  in  11 each  from `line_drawer`
- drw_done  in  1  from `line_drawer`
- pix_we  out  1  framebuffer write strobe
- pix_x, pix_y  out  11 each  write address
- pix_color  out  1  write data
- busy  out  1  state ≠ IDLE or FIFO non-empty
- err_timeout  out  1  sticky watchdog flag

## Operation
- Push: a command is written to the FIFO on a rising edge where cmd_valid && cmd_ready.
  - cmd_ready = !full.
  - No push when full, even if a pop occurs in the same cycle.
- States:
  - IDLE → LOAD: FIFO non-empty; pop into the command register.
  - LOAD → DRAW: always, after exactly one cycle.
  - DRAW → IDLE: on drw_done, or when the watchdog reaches MAX_LINE_CYCLES.
  - IDLE → CLEAR: popped command has cmd_clear=1 (macro only).
  - CLEAR → IDLE: sweep complete.
- Normalisation at pop: if cmd_x0 > cmd_x1, swap the (x0,y0) and (x1,y1) pairs. drw_x0..drw_y1 hold the normalised values from LOAD until the next pop.
- drw_reset = 1 in every state except DRAW.
- pix_we:
  - DRAW: pix_we = !drw_done, pix_x/pix_y = drw_x/drw_y (combinational pass-through), pix_color = latched pen.
  - All other states: pix_we = 0, except CLEAR.
- Watchdog: 13-bit counter.
  - Cleared in LOAD; increments each DRAW cycle.
  - On reaching MAX_LINE_CYCLES the line is aborted and err_timeout is set; it clears only on reset.
  - The sequencer continues with the next command.
- Zero-length line (x0=x1, y0=y1): exactly one write at (x0,y0).
- Duplicate pixel writes from the drawer are forwarded unchanged and are harmless.
- Reset asserted mid-operation: immediate return to IDLE, FIFO emptied, current line discarded.

## Timing
- Reset values:
  - cmd_ready=1, drw_reset=1, drw_x0..drw_y1=0
  - pix_we=0, pix_x=pix_y=0, pix_color=0
  - busy=0, err_timeout=0
- Latency from an idle sequencer:
  - Push accepted at edge N.
  - Pop at edge N+1; LOAD during cycle N+1→N+2.
  - First pixel write (x0,y0) in the first DRAW cycle, N+2→N+3.
- Line-to-line gap: 2 cycles (IDLE, LOAD).
- busy falls in the cycle IDLE is entered with the FIFO empty.

## Configuration
Macro: LINE_SEQ_CLEAR_EN.
- Defined:
  - cmd_clear=1 selects CLEAR.
  - CLEAR writes colour 0 at every pixel in raster order: x inner 0..SCREEN_W-1, y outer 0..SCREEN_H-1.
  - One write per cycle; SCREEN_W*SCREEN_H cycles total.
  - The drawer is not used during the sweep.
- Undefined:
  - cmd_clear is ignored; the command is drawn as a line.
  - The CLEAR state and its counters are absent.

## Structure
- Package `line_seq_pkg`:
  - COORD_W=11
  - `line_cmd_t` struct: x0, y0, x1, y1, pen, clear
  - `seq_state_t` enum: IDLE, LOAD, DRAW, CLEAR
- Sub-module `seq_fifo`:
  - Parameterised synchronous FIFO of `line_cmd_t` with full/empty.
  - Asynchronous reset to empty.

## Test plan
- Horizontal line (10,20)→(15,20), pen 1.
  - First write (10,20), last write (15,20), pix_x non-decreasing, pix_y=20.
  - Every write has pix_color=1.
  - Back in IDLE with busy=0.
- Reversed endpoints (15,20)→(10,20): drw_x0=10, drw_x1=15 during LOAD/DRAW.
- Point (7,7)→(7,7): exactly one write at (7,7).
- Steep line (5,5)→(6,100) with MAX_LINE_CYCLES=64.
  - Abort after 64 DRAW cycles with err_timeout=1.
  - A following line (0,0)→(3,0) still completes.
- FIFO_DEPTH=4, first line in DRAW, push continuously.
  - Four further commands accepted, then cmd_ready=0 until the next pop.
  - Reset mid-line empties the FIFO and gives pix_we=0 and busy=0 immediately.
- LINE_SEQ_CLEAR_EN defined with SCREEN_W=4, SCREEN_H=2.
  - Clear command yields 8 consecutive writes (0,0),(1,0)…(3,1), colour 0.
  - Without the macro, the same command is drawn as a line.
